// File: rtl/pgrf_pkg.sv
// Shared types and table-offset constants for the page refill sequencer.
package pgrf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [8:0] EXEC_HI_LIM = 9'o340;
  localparam logic [8:0] OFS_EXEC_HI = 9'o400;
  localparam logic [8:0] OFS_EXEC_LO = 9'o600;

endpackage

// File: rtl/pgrf_adr_calc.sv
// Page-table word address: picks base (ubr/ebr) and 9-bit table offset.
module pgrf_adr_calc
  import pgrf_pkg::*;
(
  input  logic        vma_user_i,
  input  logic [8:0]  vma_i,
  input  logic [12:0] ubr_i,
  input  logic [12:0] ebr_i,
  output logic [21:0] adr_o
);

  logic [8:0]  rel;
  logic [8:0]  ofs;
  logic [12:0] base;

  always_comb begin
    rel  = vma_i - EXEC_HI_LIM;
    ofs  = {1'b0, vma_i[8:1]};
    base = ubr_i;
    if (!vma_user_i) begin
      if (vma_i >= EXEC_HI_LIM) begin
        ofs  = OFS_EXEC_HI + (rel >> 1);
        base = ubr_i;
      end else begin
        ofs  = OFS_EXEC_LO + (vma_i >> 1);
        base = ebr_i;
      end
    end
    adr_o = {base, ofs};
  end

endmodule

// File: rtl/page_refill_seq.sv
// Page table refill sequencer: fetch one page-table word and write it.
// Optional WAIT timeout enabled by defining PGRF_TIMEOUT_EN.
module page_refill_seq
  import pgrf_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        page_refill,
  input  logic        vma_user,
  input  logic [8:0]  vma,
  input  logic [12:0] ubr,
  input  logic [12:0] ebr,
  input  logic        abort,
  input  logic        err_clr,
  input  logic        mem_ack,
  input  logic [35:0] mem_data,
  input  logic        mem_par_err,
  output logic        mem_req,
  output logic [21:0] mem_adr,
  output logic        pgrf_cyc,
  output logic        sel_1,
  output logic        sel_2,
  output logic [35:0] pt_in,
  output logic        page_refill_t12,
  output logic        page_refill_error,
  output logic        refill_done
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be positive");
  end

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [21:0] adr_q, adr_d;
  logic [35:0] pt_q, pt_d;
  logic        err_q, err_d;
  logic [21:0] calc_adr;
  logic        busy;

  pgrf_adr_calc u_adr (
    .vma_user_i (vma_user),
    .vma_i      (vma),
    .ubr_i      (ubr),
    .ebr_i      (ebr),
    .adr_o      (calc_adr)
  );

`ifdef PGRF_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;

  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_REQ) begin
      cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic tmo;
  assign tmo = 1'b0;
`endif

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    pt_d    = pt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (page_refill && !err_q) begin
          state_d = ST_REQ;
          sel_d   = vma[1:0];
          adr_d   = calc_adr;
        end
      end
      ST_REQ:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_ack) begin
          if (mem_par_err) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_WRITE;
            pt_d    = mem_data;
          end
        end else if (tmo) begin
          state_d = ST_ERR;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // abort beats a same-cycle mem_ack and never latches data
    if (abort && busy) begin
      state_d = ST_IDLE;
      pt_d    = pt_q;
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (state_q == ST_ERR && !abort) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      adr_q   <= '0;
      pt_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      pt_q    <= pt_d;
      err_q   <= err_d;
    end
  end

  assign pgrf_cyc = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                    (state_q == ST_WRITE) || (state_q == ST_DONE);
  assign mem_req  = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && !abort;
  assign page_refill_t12   = (state_q == ST_WRITE) && !abort;
  assign refill_done       = (state_q == ST_DONE) && !abort;
  assign sel_2             = pgrf_cyc && sel_q[1];
  assign sel_1             = pgrf_cyc && sel_q[0];
  assign mem_adr           = adr_q;
  assign pt_in             = pt_q;
  assign page_refill_error = err_q;

endmodule

// File: tb/tb_page_refill_seq.sv
// Directed self-checking bench for page_refill_seq.
module tb_page_refill_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        page_refill = 1'b0;
  logic        vma_user = 1'b0;
  logic [8:0]  vma = '0;
  logic [12:0] ubr = '0;
  logic [12:0] ebr = '0;
  logic        abort = 1'b0;
  logic        err_clr = 1'b0;
  logic        mem_ack = 1'b0;
  logic [35:0] mem_data = '0;
  logic        mem_par_err = 1'b0;
  logic        mem_req;
  logic [21:0] mem_adr;
  logic        pgrf_cyc;
  logic        sel_1;
  logic        sel_2;
  logic [35:0] pt_in;
  logic        t12;
  logic        err;
  logic        done;

  int checks = 0;
  int errs = 0;

  always #5 clk = ~clk;

  page_refill_seq #(.TIMEOUT_CYCLES(63)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .page_refill       (page_refill),
    .vma_user          (vma_user),
    .vma               (vma),
    .ubr               (ubr),
    .ebr               (ebr),
    .abort             (abort),
    .err_clr           (err_clr),
    .mem_ack           (mem_ack),
    .mem_data          (mem_data),
    .mem_par_err       (mem_par_err),
    .mem_req           (mem_req),
    .mem_adr           (mem_adr),
    .pgrf_cyc          (pgrf_cyc),
    .sel_1             (sel_1),
    .sel_2             (sel_2),
    .pt_in             (pt_in),
    .page_refill_t12   (t12),
    .page_refill_error (err),
    .refill_done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic usr, input logic [8:0] v,
                        input logic [12:0] u, input logic [12:0] e,
                        input int waits, input logic [35:0] d,
                        input logic [21:0] exp_adr,
                        input logic [1:0] exp_sel);
    vma_user = usr; vma = v; ubr = u; ebr = e;
    page_refill = 1'b1;
    step();
    page_refill = 1'b0;
    chk("req_cyc", pgrf_cyc, 1);
    chk("req_mem_req", mem_req, 1);
    chk("req_adr", mem_adr, exp_adr);
    chk("req_sel", {sel_2, sel_1}, exp_sel);
    vma = 9'h1ff; ubr = '0; ebr = '0;
    step();
    repeat (waits) begin
      chk("wait_req", mem_req, 1);
      chk("wait_t12", t12, 0);
      step();
    end
    mem_ack = 1'b1; mem_data = d;
    step();
    mem_ack = 1'b0; mem_data = '0;
    chk("write_t12", t12, 1);
    chk("write_req", mem_req, 0);
    chk("write_pt_in", pt_in, d);
    chk("write_done", done, 0);
    chk("write_adr_hold", mem_adr, exp_adr);
    step();
    chk("done_t12", t12, 0);
    chk("done_pulse", done, 1);
    chk("done_sel", {sel_2, sel_1}, exp_sel);
    step();
    chk("idle_done", done, 0);
    chk("idle_cyc", pgrf_cyc, 0);
    chk("idle_sel", {sel_2, sel_1}, 2'b00);
  endtask

  initial begin
    #2;
    chk("rst_req", mem_req, 0);
    chk("rst_cyc", pgrf_cyc, 0);
    chk("rst_adr", mem_adr, 0);
    chk("rst_pt", pt_in, 0);
    chk("rst_t12", t12, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    #10 rst_n = 1'b1;

    refill(1'b1, 9'o123, 13'h0100, 13'h0003, 2, 36'h9_8765_4321,
           {13'h0100, 9'o051}, 2'b11);
    refill(1'b0, 9'o345, 13'h0002, 13'h0003, 0, 36'h0_0000_00ab,
           {13'h0002, 9'o402}, 2'b01);
    refill(1'b0, 9'o010, 13'h0002, 13'h0003, 1, 36'hf_0f0f_0f0f,
           {13'h0003, 9'o604}, 2'b00);

    vma_user = 1'b1; vma = 9'o002; ubr = 13'h0010;
    page_refill = 1'b1;
    step();
    page_refill = 1'b0;
    step();
    mem_ack = 1'b1; abort = 1'b1; mem_data = 36'h1;
    step();
    mem_ack = 1'b0; abort = 1'b0;
    chk("abort_cyc", pgrf_cyc, 0);
    chk("abort_req", mem_req, 0);
    chk("abort_t12", t12, 0);
    chk("abort_pt", pt_in, 36'hf_0f0f_0f0f);
    chk("abort_err", err, 0);
    step();
    chk("abort_done", done, 0);

    page_refill = 1'b1;
    step();
    page_refill = 1'b0;
    step();
    mem_ack = 1'b1; mem_par_err = 1'b1;
    step();
    mem_ack = 1'b0; mem_par_err = 1'b0;
    chk("par_cyc", pgrf_cyc, 0);
    chk("par_t12", t12, 0);
    chk("par_req", mem_req, 0);
    step();
    chk("par_err", err, 1);
    chk("par_done", done, 0);
    chk("par_pt", pt_in, 36'hf_0f0f_0f0f);
    page_refill = 1'b1;
    step();
    chk("blocked_cyc", pgrf_cyc, 0);
    chk("blocked_req", mem_req, 0);
    step();
    chk("blocked_cyc2", pgrf_cyc, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; page_refill = 1'b0;
    chk("err_cleared", err, 0);
    chk("clr_cyc", pgrf_cyc, 0);

    page_refill = 1'b1;
    step();
    page_refill = 1'b0;
    step();
    mem_ack = 1'b1; mem_par_err = 1'b1;
    step();
    mem_ack = 1'b0; mem_par_err = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_wins", err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr2", err, 0);

    page_refill = 1'b1;
    step();
    page_refill = 1'b0;
    step();
`ifdef PGRF_TIMEOUT_EN
    step(62);
    chk("tmo_wait_cyc", pgrf_cyc, 1);
    chk("tmo_wait_err", err, 0);
    step();
    chk("tmo_err_state", pgrf_cyc, 0);
    step();
    chk("tmo_flag", err, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("tmo_clr", err, 0);
`else
    step(1000);
    chk("notmo_cyc", pgrf_cyc, 1);
    chk("notmo_req", mem_req, 1);
    chk("notmo_err", err, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("notmo_abort", pgrf_cyc, 0);
`endif

    page_refill = 1'b1;
    step();
    page_refill = 1'b0;
    step();
    mem_ack = 1'b1; mem_data = 36'h5;
    step();
    mem_ack = 1'b0;
    chk("rstw_pre_t12", t12, 1);
    rst_n = 1'b0;
    #1;
    chk("rstw_t12", t12, 0);
    chk("rstw_cyc", pgrf_cyc, 0);
    chk("rstw_pt", pt_in, 0);
    chk("rstw_adr", mem_adr, 0);
    chk("rstw_req", mem_req, 0);
    step();
    #3 rst_n = 1'b1;
    step();
    chk("rstw_post_t12", t12, 0);
    chk("rstw_post_done", done, 0);
    chk("rstw_post_cyc", pgrf_cyc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
